// File: rtl/id_stage_hdu_if.sv
// id_stage_hdu_if: ID-stage inputs (IF, WB, EX/MEM) and ID/EX pipeline outputs.
interface id_stage_hdu_if #(
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;
  logic [0:31] ID_inst;
  logic ID_valid;
  logic WB_wrEn;
  logic [4:0] WB_rD;
  logic [0:BE_W-1] WB_be;
  logic [DATA_W-1:0] WB_rD_data;
  logic [4:0] EX_MEM_rD;
  logic EX_MEM_wrEn;
  logic EX_MEM_memEn;
  logic [DATA_W-1:0] EX_MEM_data;
  logic ID_stall;
  logic ID_br_ctrl;
  logic [15:0] ID_imm_addr;
  logic EX_valid;
  logic [5:0] EX_op_code;
  logic [4:0] EX_rD;
  logic EX_wrEn;
  logic EX_memEn;
  logic EX_memwrEn;
  logic [DATA_W-1:0] EX_rA_data;
  logic [DATA_W-1:0] EX_rB_data;
  logic EX_fwd_A;
  logic EX_fwd_B;
  logic [15:0] EX_imm;
  modport master (
    output ID_inst, ID_valid, WB_wrEn, WB_rD, WB_be, WB_rD_data,
           EX_MEM_rD, EX_MEM_wrEn, EX_MEM_memEn, EX_MEM_data,
    input  ID_stall, ID_br_ctrl, ID_imm_addr, EX_valid, EX_op_code, EX_rD, EX_wrEn,
           EX_memEn, EX_memwrEn, EX_rA_data, EX_rB_data, EX_fwd_A, EX_fwd_B, EX_imm
  );
  modport slave (
    input  ID_inst, ID_valid, WB_wrEn, WB_rD, WB_be, WB_rD_data,
           EX_MEM_rD, EX_MEM_wrEn, EX_MEM_memEn, EX_MEM_data,
    output ID_stall, ID_br_ctrl, ID_imm_addr, EX_valid, EX_op_code, EX_rD, EX_wrEn,
           EX_memEn, EX_memwrEn, EX_rA_data, EX_rB_data, EX_fwd_A, EX_fwd_B, EX_imm
  );
endinterface

// File: rtl/id_stage_hdu.sv
// id_stage_hdu: decode stage with byte-lane RF, load-use/branch hazard stall, fwd selects and ID/EX register; `define ID_BR_FWD_EN forwards EX/MEM ALU results to branches.
module id_stage_hdu #(
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 32
) (
  input logic clk,
  input logic reset,
  id_stage_hdu_if.slave b
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [5:0] OP_ALU = 6'b101010, OP_LD = 6'b100000, OP_SD = 6'b100001;
  localparam logic [5:0] OP_BEZ = 6'b100010, OP_BNEZ = 6'b100011;
  logic [5:0] op;
  logic [4:0] rd, ra, rb, rs;
  logic is_alu, is_ld, is_sd, is_bez, is_bnez, is_br, use_a, use_b;
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] wb_mask, wb_new, a_val, b_rf, b_val;
  logic wb_ok, load_use, mem_hit, mem_fwd, mem_stall, br_haz, stall, taken, load;
  function automatic logic in_range(input logic [4:0] a);
    return a != 5'd0 && {1'b0, a} < 6'(NUM_REGS);
  endfunction
  assign op = b.ID_inst[0:5];
  assign rd = b.ID_inst[6:10];
  assign ra = b.ID_inst[11:15];
  assign rb = b.ID_inst[16:20];
  assign is_alu = op == OP_ALU;
  assign is_ld = op == OP_LD;
  assign is_sd = op == OP_SD;
  assign is_bez = op == OP_BEZ;
  assign is_bnez = op == OP_BNEZ;
  assign is_br = is_bez | is_bnez;
  assign use_a = is_alu | is_ld | is_sd;
  assign use_b = is_alu | is_sd | is_br;
  assign rs = (is_sd | is_br) ? rd : rb;
  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    assign wb_mask[DATA_W-1-8*g -: 8] = {8{b.WB_be[g]}};
  end
  // The merged write value doubles as the same-cycle read bypass
  assign wb_ok = b.WB_wrEn & in_range(b.WB_rD);
  assign wb_new = (rf[b.WB_rD] & ~wb_mask) | (b.WB_rD_data & wb_mask);
  assign a_val = !in_range(ra) ? '0 : (wb_ok && b.WB_rD == ra) ? wb_new : rf[ra];
  assign b_rf = !in_range(rs) ? '0 : (wb_ok && b.WB_rD == rs) ? wb_new : rf[rs];
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wb_ok) rf[b.WB_rD] <= wb_new;
  end
  assign load_use = b.EX_valid & b.EX_memEn & !b.EX_memwrEn & (b.EX_rD != 5'd0) &
                    ((use_a & (b.EX_rD == ra)) | (use_b & (b.EX_rD == rs)));
  assign mem_hit = b.EX_MEM_wrEn & (b.EX_MEM_rD == rs) & (rs != 5'd0);
`ifdef ID_BR_FWD_EN
  assign mem_fwd = mem_hit & !b.EX_MEM_memEn;
  assign mem_stall = mem_hit & b.EX_MEM_memEn;
`else
  assign mem_fwd = 1'b0;
  assign mem_stall = mem_hit;
`endif
  assign br_haz = is_br & ((b.EX_valid & b.EX_wrEn & (b.EX_rD == rs) & (rs != 5'd0)) | mem_stall);
  assign stall = !reset & b.ID_valid & (load_use | br_haz);
  assign b_val = mem_fwd ? b.EX_MEM_data : b_rf;
  assign taken = (is_bez & (b_val == '0)) | (is_bnez & (b_val != '0));
  assign load = b.ID_valid & !stall;
  assign b.ID_stall = stall;
  assign b.ID_br_ctrl = !reset & load & taken;
  assign b.ID_imm_addr = b.ID_inst[16:31];
  always_ff @(posedge clk) begin
    if (reset || !load) begin
      b.EX_valid <= 1'b0;
      b.EX_op_code <= '0;
      b.EX_rD <= '0;
      b.EX_wrEn <= 1'b0;
      b.EX_memEn <= 1'b0;
      b.EX_memwrEn <= 1'b0;
      b.EX_rA_data <= '0;
      b.EX_rB_data <= '0;
      b.EX_fwd_A <= 1'b0;
      b.EX_fwd_B <= 1'b0;
      b.EX_imm <= '0;
    end else begin
      b.EX_valid <= 1'b1;
      b.EX_op_code <= op;
      b.EX_rD <= rd;
      b.EX_wrEn <= is_alu | is_ld;
      b.EX_memEn <= is_ld | is_sd;
      b.EX_memwrEn <= is_sd;
      b.EX_rA_data <= a_val;
      b.EX_rB_data <= b_val;
      b.EX_fwd_A <= b.EX_valid & b.EX_wrEn & (b.EX_rD == ra) & (ra != 5'd0);
      b.EX_fwd_B <= b.EX_valid & b.EX_wrEn & (b.EX_rD == rs) & (rs != 5'd0);
      b.EX_imm <= b.ID_inst[16:31];
    end
  end
endmodule

// File: tb/tb_id_stage_hdu.sv
// tb_id_stage_hdu: directed scenarios plus randomized run against a behavioural decode model.
module tb_id_stage_hdu;
  localparam logic [5:0] ALU = 6'b101010, LD = 6'b100000, SD = 6'b100001;
  localparam logic [5:0] BEZ = 6'b100010, BNEZ = 6'b100011, NOP = 6'b111100;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0, n_fail = 0;
  logic [63:0] mr [32];
  always #5 clk = ~clk;
  id_stage_hdu_if #(.DATA_W(64)) bi ();
  id_stage_hdu #(.DATA_W(64), .NUM_REGS(32)) dut (.clk(clk), .reset(reset), .b(bi));
  function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] d, input logic [4:0] a, input logic [15:0] low);
    return {o, d, a, low};
  endfunction
  function automatic logic [15:0] rbf(input logic [4:0] r);
    return {r, 11'd0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bi.ID_inst = mk(NOP, 0, 0, 0);
    bi.ID_valid = 1'b1;
    bi.WB_wrEn = 1'b0;
    bi.WB_rD = '0;
    bi.WB_be = '0;
    bi.WB_rD_data = '0;
    bi.EX_MEM_rD = '0;
    bi.EX_MEM_wrEn = 1'b0;
    bi.EX_MEM_memEn = 1'b0;
    bi.EX_MEM_data = '0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle();
    bi.ID_inst = mk(ALU, 1, 2, rbf(3));
    tick();
    tick();
    n_checks++; if (bi.EX_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%0h exp=0", bi.EX_valid); end
    n_checks++; if (bi.EX_rD !== 5'd0 || bi.EX_op_code !== 6'd0 || bi.EX_wrEn !== 1'b0) begin n_fail++; $display("FAIL reset_ex_ctrl got=%0h/%0h/%0h exp=0", bi.EX_rD, bi.EX_op_code, bi.EX_wrEn); end
    n_checks++; if (bi.ID_stall !== 1'b0 || bi.ID_br_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_id got=%0h/%0h exp=0", bi.ID_stall, bi.ID_br_ctrl); end
    reset = 1'b0;
  endtask
  task automatic test_rf_writeback();
    bi.WB_wrEn = 1'b1; bi.WB_rD = 3; bi.WB_be = 8'hFF; bi.WB_rD_data = 64'h1122334455667788;
    bi.ID_inst = mk(ALU, 10, 3, rbf(0));
    tick();
    n_checks++; if (bi.EX_rA_data !== 64'h1122334455667788) begin n_fail++; $display("FAIL rf_bypass got=%h exp=1122334455667788", bi.EX_rA_data); end
    n_checks++; if (bi.EX_rB_data !== 64'd0 || bi.EX_valid !== 1'b1 || bi.EX_wrEn !== 1'b1) begin n_fail++; $display("FAIL rf_r0_ctrl got=%h/%0h/%0h exp=0/1/1", bi.EX_rB_data, bi.EX_valid, bi.EX_wrEn); end
    bi.WB_be = 8'h01; bi.WB_rD_data = '1; bi.ID_inst = mk(NOP, 0, 0, 0);
    tick();
    bi.WB_rD = 0; bi.WB_be = 8'hFF;
    bi.ID_inst = mk(ALU, 11, 3, rbf(0));
    tick();
    n_checks++; if (bi.EX_rA_data !== 64'h11223344556677FF) begin n_fail++; $display("FAIL rf_lane_low got=%h exp=11223344556677ff", bi.EX_rA_data); end
    n_checks++; if (bi.EX_rB_data !== 64'd0) begin n_fail++; $display("FAIL rf_r0_write got=%h exp=0", bi.EX_rB_data); end
    bi.WB_rD = 3; bi.WB_be = 8'h80; bi.WB_rD_data = 64'hAA00000000000000;
    bi.ID_inst = mk(ALU, 11, 3, rbf(3));
    tick();
    n_checks++; if (bi.EX_rA_data !== 64'hAA223344556677FF || bi.EX_rB_data !== 64'hAA223344556677FF) begin n_fail++; $display("FAIL rf_lane_high got=%h/%h exp=aa223344556677ff", bi.EX_rA_data, bi.EX_rB_data); end
    bi.WB_rD = 1; bi.WB_be = 8'hFF; bi.WB_rD_data = 64'h0123456789ABCDEF; bi.ID_inst = mk(NOP, 0, 0, 0);
    tick();
    bi.WB_rD = 2; bi.WB_rD_data = 64'h5;
    tick();
    bi.WB_wrEn = 1'b0;
  endtask
  task automatic test_load_use();
    bi.ID_inst = mk(LD, 5, 1, 16'h0010);
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0) begin n_fail++; $display("FAIL lu_ld_nostall got=%0h exp=0", bi.ID_stall); end
    tick();
    n_checks++; if (bi.EX_memEn !== 1'b1 || bi.EX_rD !== 5'd5 || bi.EX_memwrEn !== 1'b0) begin n_fail++; $display("FAIL lu_ld_ex got=%0h/%0d/%0h exp=1/5/0", bi.EX_memEn, bi.EX_rD, bi.EX_memwrEn); end
    bi.ID_inst = mk(ALU, 6, 5, rbf(1));
    #1;
    n_checks++; if (bi.ID_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0h exp=1", bi.ID_stall); end
    tick();
    n_checks++; if (bi.EX_valid !== 1'b0 || bi.EX_op_code !== 6'd0) begin n_fail++; $display("FAIL lu_bubble got=%0h/%0h exp=0/0", bi.EX_valid, bi.EX_op_code); end
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release got=%0h exp=0", bi.ID_stall); end
    tick();
    n_checks++; if (bi.EX_valid !== 1'b1 || bi.EX_rD !== 5'd6 || bi.EX_fwd_A !== 1'b0) begin n_fail++; $display("FAIL lu_after got=%0h/%0d/%0h exp=1/6/0", bi.EX_valid, bi.EX_rD, bi.EX_fwd_A); end
    bi.ID_inst = mk(LD, 5, 1, 0);
    tick();
    bi.ID_inst = mk(SD, 5, 2, 0);
    #1;
    n_checks++; if (bi.ID_stall !== 1'b1) begin n_fail++; $display("FAIL lu_store_rd got=%0h exp=1", bi.ID_stall); end
    tick();
    bi.ID_inst = mk(LD, 0, 1, 0);
    tick();
    bi.ID_inst = mk(ALU, 6, 0, rbf(0));
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got=%0h exp=0", bi.ID_stall); end
    tick();
  endtask
  task automatic test_alu_fwd();
    bi.ID_inst = mk(ALU, 7, 1, rbf(2));
    tick();
    bi.ID_inst = mk(ALU, 8, 7, rbf(7));
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0) begin n_fail++; $display("FAIL fwd_nostall got=%0h exp=0", bi.ID_stall); end
    tick();
    n_checks++; if (bi.EX_fwd_A !== 1'b1 || bi.EX_fwd_B !== 1'b1) begin n_fail++; $display("FAIL fwd_both got=%0h/%0h exp=1/1", bi.EX_fwd_A, bi.EX_fwd_B); end
    bi.ID_inst = mk(ALU, 9, 1, rbf(2));
    tick();
    n_checks++; if (bi.EX_fwd_A !== 1'b0 || bi.EX_fwd_B !== 1'b0) begin n_fail++; $display("FAIL fwd_none got=%0h/%0h exp=0/0", bi.EX_fwd_A, bi.EX_fwd_B); end
    bi.ID_inst = mk(SD, 9, 1, 0);
    tick();
    n_checks++; if (bi.EX_fwd_A !== 1'b0 || bi.EX_fwd_B !== 1'b1) begin n_fail++; $display("FAIL fwd_store got=%0h/%0h exp=0/1", bi.EX_fwd_A, bi.EX_fwd_B); end
  endtask
  task automatic test_branch();
    bi.ID_inst = mk(NOP, 0, 0, 0);
    tick();
    bi.ID_inst = mk(BEZ, 4, 0, 16'h0040);
    #1;
    n_checks++; if (bi.ID_br_ctrl !== 1'b1 || bi.ID_imm_addr !== 16'h0040 || bi.ID_stall !== 1'b0) begin n_fail++; $display("FAIL br_bez got=%0h/%h/%0h exp=1/0040/0", bi.ID_br_ctrl, bi.ID_imm_addr, bi.ID_stall); end
    tick();
    n_checks++; if (bi.EX_valid !== 1'b1 || bi.EX_wrEn !== 1'b0 || bi.EX_op_code !== BEZ) begin n_fail++; $display("FAIL br_in_ex got=%0h/%0h/%b exp=1/0/%b", bi.EX_valid, bi.EX_wrEn, bi.EX_op_code, BEZ); end
    bi.ID_inst = mk(BNEZ, 4, 0, 16'h0040);
    #1;
    n_checks++; if (bi.ID_br_ctrl !== 1'b0) begin n_fail++; $display("FAIL br_bnez_zero got=%0h exp=0", bi.ID_br_ctrl); end
    tick();
    bi.ID_inst = mk(BNEZ, 3, 0, 16'h0080);
    #1;
    n_checks++; if (bi.ID_br_ctrl !== 1'b1) begin n_fail++; $display("FAIL br_bnez_taken got=%0h exp=1", bi.ID_br_ctrl); end
    bi.ID_valid = 1'b0;
    #1;
    n_checks++; if (bi.ID_br_ctrl !== 1'b0) begin n_fail++; $display("FAIL br_invalid got=%0h exp=0", bi.ID_br_ctrl); end
    tick();
    bi.ID_valid = 1'b1;
  endtask
  task automatic test_branch_stall();
    bi.ID_inst = mk(NOP, 0, 0, 0);
    tick();
    bi.EX_MEM_wrEn = 1'b1; bi.EX_MEM_rD = 9; bi.EX_MEM_memEn = 1'b0; bi.EX_MEM_data = '0;
    bi.ID_inst = mk(BEZ, 9, 0, 16'h0100);
    #1;
`ifdef ID_BR_FWD_EN
    n_checks++; if (bi.ID_stall !== 1'b0 || bi.ID_br_ctrl !== 1'b1) begin n_fail++; $display("FAIL brs_exmem got=%0h/%0h exp=0/1", bi.ID_stall, bi.ID_br_ctrl); end
    tick();
    n_checks++; if (bi.EX_valid !== 1'b1) begin n_fail++; $display("FAIL brs_exmem_ex got=%0h exp=1", bi.EX_valid); end
`else
    n_checks++; if (bi.ID_stall !== 1'b1 || bi.ID_br_ctrl !== 1'b0) begin n_fail++; $display("FAIL brs_exmem got=%0h/%0h exp=1/0", bi.ID_stall, bi.ID_br_ctrl); end
    tick();
    n_checks++; if (bi.EX_valid !== 1'b0) begin n_fail++; $display("FAIL brs_exmem_ex got=%0h exp=0", bi.EX_valid); end
`endif
    bi.EX_MEM_wrEn = 1'b0;
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0 || bi.ID_br_ctrl !== 1'b1) begin n_fail++; $display("FAIL brs_clear got=%0h/%0h exp=0/1", bi.ID_stall, bi.ID_br_ctrl); end
    tick();
    bi.EX_MEM_wrEn = 1'b1; bi.EX_MEM_memEn = 1'b1;
    #1;
    n_checks++; if (bi.ID_stall !== 1'b1) begin n_fail++; $display("FAIL brs_load got=%0h exp=1", bi.ID_stall); end
    tick();
    bi.EX_MEM_wrEn = 1'b0; bi.EX_MEM_memEn = 1'b0;
    bi.ID_inst = mk(ALU, 12, 1, rbf(2));
    tick();
    bi.ID_inst = mk(BEZ, 12, 0, 16'h0200);
    #1;
    n_checks++; if (bi.ID_stall !== 1'b1) begin n_fail++; $display("FAIL brs_ex_prod got=%0h exp=1", bi.ID_stall); end
    reset = 1'b1;
    #1;
    n_checks++; if (bi.ID_stall !== 1'b0 || bi.ID_br_ctrl !== 1'b0) begin n_fail++; $display("FAIL brs_rst_id got=%0h/%0h exp=0/0", bi.ID_stall, bi.ID_br_ctrl); end
    tick();
    n_checks++; if ({bi.EX_valid, bi.EX_rD, bi.EX_op_code, bi.EX_wrEn, bi.EX_fwd_A, bi.EX_imm} !== '0 || bi.EX_rA_data !== '0 || bi.EX_rB_data !== '0) begin n_fail++; $display("FAIL brs_rst_ex got=%0h/%0d/%h exp=all zero", bi.EX_valid, bi.EX_rD, bi.EX_rA_data); end
    reset = 1'b0;
  endtask
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] v = old;
    for (int j = 0; j < 8; j++) if (be[j]) v[8*j +: 8] = nw[8*j +: 8];
    return v;
  endfunction
  task automatic test_random();
    logic [31:0] inst;
    logic [5:0] o;
    logic [4:0] d, a, s, wbrd;
    logic [7:0] be;
    logic [63:0] bval, aval, wbd, memd;
    logic alu, ld, sd, bez, bnez, br, use_a, use_b, lu, hit, fwd, mst, bh, x_stall, x_br, ldn;
    logic e_valid, e_wr, e_mem, e_memwr, e_fa, e_fb;
    logic [5:0] e_op;
    logic [4:0] e_rd;
    logic [63:0] e_a, e_b;
    logic [15:0] e_imm;
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    {e_valid, e_wr, e_mem, e_memwr, e_fa, e_fb, e_op, e_rd, e_a, e_b, e_imm} = '0;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 6))
        0: o = ALU;
        1: o = LD;
        2: o = SD;
        3: o = BEZ;
        4: o = BNEZ;
        5: o = NOP;
        default: o = 6'($urandom);
      endcase
      inst = {o, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 11'($urandom)};
      reset = $urandom_range(0, 63) == 0;
      bi.ID_inst = inst;
      bi.ID_valid = $urandom_range(0, 9) != 0;
      bi.WB_wrEn = $urandom_range(0, 1) == 1;
      bi.WB_rD = 5'($urandom_range(0, 5));
      bi.WB_be = 8'($urandom);
      bi.WB_rD_data = {$urandom, $urandom};
      bi.EX_MEM_wrEn = $urandom_range(0, 1) == 1;
      bi.EX_MEM_rD = 5'($urandom_range(0, 5));
      bi.EX_MEM_memEn = $urandom_range(0, 1) == 1;
      bi.EX_MEM_data = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      #1;
      be = bi.WB_be; wbrd = bi.WB_rD; wbd = bi.WB_rD_data; memd = bi.EX_MEM_data;
      d = inst[25:21]; a = inst[20:16];
      alu = o == ALU; ld = o == LD; sd = o == SD; bez = o == BEZ; bnez = o == BNEZ; br = bez || bnez;
      s = (sd || br) ? d : inst[15:11];
      use_a = alu || ld || sd; use_b = alu || sd || br;
      lu = e_valid && e_mem && !e_memwr && e_rd != 0 && ((use_a && e_rd == a) || (use_b && e_rd == s));
      hit = bi.EX_MEM_wrEn && bi.EX_MEM_rD == s && s != 0;
`ifdef ID_BR_FWD_EN
      fwd = hit && !bi.EX_MEM_memEn; mst = hit && bi.EX_MEM_memEn;
`else
      fwd = 1'b0; mst = hit;
`endif
      bh = br && ((e_valid && e_wr && e_rd == s && s != 0) || mst);
      x_stall = !reset && bi.ID_valid && (lu || bh);
      aval = a == 0 ? 64'd0 : (bi.WB_wrEn && wbrd == a) ? merge(mr[a], wbd, be) : mr[a];
      bval = s == 0 ? 64'd0 : (bi.WB_wrEn && wbrd == s) ? merge(mr[s], wbd, be) : mr[s];
      if (fwd) bval = memd;
      x_br = !reset && bi.ID_valid && !x_stall && ((bez && bval == 0) || (bnez && bval != 0));
      n_checks++; if (bi.ID_stall !== x_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0h exp=%0h", c, bi.ID_stall, x_stall); end
      n_checks++; if (bi.ID_br_ctrl !== x_br || bi.ID_imm_addr !== inst[15:0]) begin n_fail++; $display("FAIL rnd_branch c=%0d got=%0h/%h exp=%0h/%h", c, bi.ID_br_ctrl, bi.ID_imm_addr, x_br, inst[15:0]); end
      ldn = !reset && bi.ID_valid && !x_stall;
      e_fa = ldn && e_valid && e_wr && e_rd == a && a != 0;
      e_fb = ldn && e_valid && e_wr && e_rd == s && s != 0;
      e_valid = ldn;
      e_op = ldn ? o : 6'd0;
      e_rd = ldn ? d : 5'd0;
      e_wr = ldn && (alu || ld);
      e_mem = ldn && (ld || sd);
      e_memwr = ldn && sd;
      e_a = ldn ? aval : 64'd0;
      e_b = ldn ? bval : 64'd0;
      e_imm = ldn ? inst[15:0] : 16'd0;
      if (reset) for (int i = 0; i < 32; i++) mr[i] = '0;
      else if (bi.WB_wrEn && wbrd != 0) mr[wbrd] = merge(mr[wbrd], wbd, be);
      tick();
      n_checks++; if ({bi.EX_valid, bi.EX_op_code, bi.EX_rD, bi.EX_wrEn, bi.EX_memEn, bi.EX_memwrEn, bi.EX_imm} !== {e_valid, e_op, e_rd, e_wr, e_mem, e_memwr, e_imm}) begin n_fail++; $display("FAIL rnd_ex_ctrl c=%0d got=%0h/%b/%0d/%0h%0h%0h/%h exp=%0h/%b/%0d/%0h%0h%0h/%h", c, bi.EX_valid, bi.EX_op_code, bi.EX_rD, bi.EX_wrEn, bi.EX_memEn, bi.EX_memwrEn, bi.EX_imm, e_valid, e_op, e_rd, e_wr, e_mem, e_memwr, e_imm); end
      n_checks++; if (bi.EX_rA_data !== e_a || bi.EX_rB_data !== e_b) begin n_fail++; $display("FAIL rnd_ex_data c=%0d got=%h/%h exp=%h/%h", c, bi.EX_rA_data, bi.EX_rB_data, e_a, e_b); end
      n_checks++; if (bi.EX_fwd_A !== e_fa || bi.EX_fwd_B !== e_fb) begin n_fail++; $display("FAIL rnd_fwd c=%0d got=%0h/%0h exp=%0h/%0h", c, bi.EX_fwd_A, bi.EX_fwd_B, e_fa, e_fb); end
    end
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_rf_writeback();
    test_load_use();
    test_alu_fwd();
    test_branch();
    test_branch_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
